// File: rtl/cache_control_unit.sv
// -----------------------------------------------------------------------------
// cache_control_unit
//
// Purpose:
//   Moore FSM controlling a 2-way set-associative, write-through,
//   no-write-allocate CPU cache with FIFO replacement. It sequences the system
//   request handshake (sys_rd/sys_wr -> sys_ack) against the RAM handshake
//   (ram_avalid/ram_wr -> ram_ack). It also drives the cache datapath write
//   enables and the data/way multiplexers.
//
//   Every output is a flop. Each output's next value is decoded from the next
//   state, so the outputs always match the state register. No input reaches an
//   output through combinational logic. The fill way (fifo) is captured at the
//   moment the FSM enters FILL.
//
// Optional feature (macro CU_RAM_TIMEOUT_EN):
//   Defining CU_RAM_TIMEOUT_EN adds the parameter RAM_TIMEOUT (default 255), a
//   wait-cycle counter and the sys_err output.
//   - A read or write miss that waits RAM_TIMEOUT cycles without ram_ack ends
//     in ERR. ERR pulses sys_ack and sys_err for one cycle.
//   - A write-through that times out returns silently to IDLE.
//   Without the macro, RAM waits are unbounded and sys_err does not exist.
//
// Ports:
//   clk            in   system clock, rising edge
//   not_reset      in   asynchronous active-low reset
//   sys_rd         in   system read request, held until sys_ack
//   sys_wr         in   system write request, held until sys_ack
//   hit            in   tag match in either way (valid in LOOKUP)
//   fifo           in   FIFO victim way of the addressed set
//   ram_ack        in   RAM transfer complete, single-cycle pulse
//   ram_avalid     out  RAM address/command valid
//   ram_wr         out  RAM command is a write
//   wr_tag         out  write tag/valid of the selected way
//   wr             out  write data array of the selected way
//   select_data    out  0 = cache data from system, 1 = from RAM
//   select_channel out  way select for fills
//   sys_ack        out  request complete
//   sys_err        out  RAM timeout error (only with CU_RAM_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module cache_control_unit
`ifdef CU_RAM_TIMEOUT_EN
  #(parameter int unsigned RAM_TIMEOUT = 255)
`endif
(
  input  logic clk,
  input  logic not_reset,
  input  logic sys_rd,
  input  logic sys_wr,
  input  logic hit,
  input  logic fifo,
  input  logic ram_ack,
  output logic ram_avalid,
  output logic ram_wr,
  output logic wr_tag,
  output logic wr,
  output logic select_data,
  output logic select_channel,
  output logic sys_ack
`ifdef CU_RAM_TIMEOUT_EN
  ,
  output logic sys_err
`endif
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOOKUP  = 4'd1,
    RD_HIT  = 4'd2,
    WR_HIT  = 4'd3,
    WR_THRU = 4'd4,
    WR_MEM  = 4'd5,
    RD_MEM  = 4'd6,
    FILL    = 4'd7,
    ACK_MEM = 4'd8,
    ERR     = 4'd9
  } state_t;

  state_t state_r;
  state_t state_next_s;

  // Next values of the registered outputs
  logic ram_avalid_next_s;
  logic ram_wr_next_s;
  logic wr_tag_next_s;
  logic wr_next_s;
  logic select_data_next_s;
  logic select_channel_next_s;
  logic sys_ack_next_s;
  logic sys_err_next_s;

  // Raised on the last permitted RAM wait cycle when no ram_ack has arrived
  logic timeout_s;

`ifdef CU_RAM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(RAM_TIMEOUT + 1) > 8) ? $clog2(RAM_TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_r;
  logic             in_wait_s;
  logic             sys_err_r;

  // Identify the RAM wait states and detect the timeout limit
  always_comb begin
    in_wait_s = 1'b0;
    timeout_s = 1'b0;
    if ((state_r == RD_MEM) || (state_r == WR_MEM) || (state_r == WR_THRU)) begin
      in_wait_s = 1'b1;
    end else begin
      in_wait_s = 1'b0;
    end
    if (in_wait_s && !ram_ack && (wait_cnt_r == CNT_W'(RAM_TIMEOUT - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Wait counter: cleared on every state change, counts cycles spent waiting
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      wait_cnt_r <= '0;
    end else if (state_next_s != state_r) begin
      wait_cnt_r <= '0;
    end else if (in_wait_s) begin
      wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign sys_err = sys_err_r;
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (sys_rd || sys_wr) begin
          state_next_s = LOOKUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOOKUP: begin
        if (sys_rd) begin
          state_next_s = hit ? RD_HIT : RD_MEM;
        end else if (sys_wr) begin
          state_next_s = hit ? WR_HIT : WR_MEM;
        end else begin
          state_next_s = IDLE;
        end
      end
      RD_HIT, FILL, ACK_MEM: begin
        // A request seen during an ack cycle is a new request
        if (sys_rd || sys_wr) begin
          state_next_s = LOOKUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_HIT: begin
        state_next_s = WR_THRU;
      end
      WR_THRU: begin
        // The write-through is already acknowledged, so a timeout is silent
        if (ram_ack || timeout_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WR_THRU;
        end
      end
      WR_MEM: begin
        if (ram_ack) begin
          state_next_s = ACK_MEM;
        end else if (timeout_s) begin
          state_next_s = ERR;
        end else begin
          state_next_s = WR_MEM;
        end
      end
      RD_MEM: begin
        if (ram_ack) begin
          state_next_s = FILL;
        end else if (timeout_s) begin
          state_next_s = ERR;
        end else begin
          state_next_s = RD_MEM;
        end
      end
      ERR: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the output flops follow the state
  always_comb begin
    ram_avalid_next_s     = 1'b0;
    ram_wr_next_s         = 1'b0;
    wr_tag_next_s         = 1'b0;
    wr_next_s             = 1'b0;
    select_data_next_s    = 1'b0;
    select_channel_next_s = 1'b0;
    sys_ack_next_s        = 1'b0;
    sys_err_next_s        = 1'b0;
    case (state_next_s)
      IDLE, LOOKUP: begin
        sys_ack_next_s = 1'b0;
      end
      RD_HIT, ACK_MEM: begin
        sys_ack_next_s = 1'b1;
      end
      WR_HIT: begin
        wr_next_s          = 1'b1;
        select_data_next_s = 1'b0;
        sys_ack_next_s     = 1'b1;
      end
      WR_THRU, WR_MEM: begin
        ram_avalid_next_s = 1'b1;
        ram_wr_next_s     = 1'b1;
      end
      RD_MEM: begin
        ram_avalid_next_s = 1'b1;
        ram_wr_next_s     = 1'b0;
      end
      FILL: begin
        wr_next_s             = 1'b1;
        wr_tag_next_s         = 1'b1;
        select_data_next_s    = 1'b1;
        select_channel_next_s = fifo;
        sys_ack_next_s        = 1'b1;
      end
      ERR: begin
        sys_ack_next_s = 1'b1;
        sys_err_next_s = 1'b1;
      end
      default: begin
        sys_ack_next_s = 1'b0;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_r        <= IDLE;
      ram_avalid     <= 1'b0;
      ram_wr         <= 1'b0;
      wr_tag         <= 1'b0;
      wr             <= 1'b0;
      select_data    <= 1'b0;
      select_channel <= 1'b0;
      sys_ack        <= 1'b0;
`ifdef CU_RAM_TIMEOUT_EN
      sys_err_r      <= 1'b0;
`endif
    end else begin
      state_r        <= state_next_s;
      ram_avalid     <= ram_avalid_next_s;
      ram_wr         <= ram_wr_next_s;
      wr_tag         <= wr_tag_next_s;
      wr             <= wr_next_s;
      select_data    <= select_data_next_s;
      select_channel <= select_channel_next_s;
      sys_ack        <= sys_ack_next_s;
`ifdef CU_RAM_TIMEOUT_EN
      sys_err_r      <= sys_err_next_s;
`endif
    end
  end

endmodule

// File: tb/tb_cache_control_unit.sv
// -----------------------------------------------------------------------------
// tb_cache_control_unit
//
// Directed testbench for cache_control_unit in its default build (no RAM
// timeout). Inputs change 1 time unit after a rising edge. Outputs are checked
// at that same point, so every check sees the state entered on that edge.
// The outputs are compared as one packed vector:
//   {ram_avalid, ram_wr, wr_tag, wr, select_data, select_channel, sys_ack}
// -----------------------------------------------------------------------------
module tb_cache_control_unit;

  logic clk;
  logic not_reset;
  logic sys_rd;
  logic sys_wr;
  logic hit;
  logic fifo;
  logic ram_ack;
  logic ram_avalid;
  logic ram_wr;
  logic wr_tag;
  logic wr;
  logic select_data;
  logic select_channel;
  logic sys_ack;

  int total;
  int bad;

  // Expected output vectors, one per state
  localparam logic [6:0] O_IDLE = 7'b000_0000;
  localparam logic [6:0] O_ACK  = 7'b000_0001;
  localparam logic [6:0] O_WHIT = 7'b000_1001;
  localparam logic [6:0] O_RAMW = 7'b110_0000;
  localparam logic [6:0] O_RAMR = 7'b100_0000;
  localparam logic [6:0] O_FIL1 = 7'b001_1111;

  cache_control_unit dut (
    .clk            (clk),
    .not_reset      (not_reset),
    .sys_rd         (sys_rd),
    .sys_wr         (sys_wr),
    .hit            (hit),
    .fifo           (fifo),
    .ram_ack        (ram_ack),
    .ram_avalid     (ram_avalid),
    .ram_wr         (ram_wr),
    .wr_tag         (wr_tag),
    .wr             (wr),
    .select_data    (select_data),
    .select_channel (select_channel),
    .sys_ack        (sys_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {ram_avalid, ram_wr, wr_tag, wr, select_data, select_channel, sys_ack};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    not_reset = 1'b0;
    sys_rd    = 1'b0;
    sys_wr    = 1'b0;
    hit       = 1'b0;
    fifo      = 1'b0;
    ram_ack   = 1'b0;
    #12;
    chk("reset", O_IDLE);
    @(negedge clk);
    not_reset = 1'b1;
    step();
    chk("idle_after_reset", O_IDLE);

    // Read hit
    sys_rd = 1'b1; hit = 1'b1; fifo = 1'b0;
    step(); chk("rdhit_lookup", O_IDLE);
    step(); chk("rdhit_ack", O_ACK);

    // Write hit directly after the read ack
    sys_rd = 1'b0; sys_wr = 1'b1;
    step(); chk("wrhit_lookup", O_IDLE);
    step(); chk("wrhit_ack", O_WHIT);
    sys_wr = 1'b0;
    step(); chk("wrthru_1", O_RAMW);
    step(); chk("wrthru_2", O_RAMW);
    ram_ack = 1'b1;
    step(); chk("wrthru_done_idle", O_IDLE);
    ram_ack = 1'b0;

    // A ram_ack pulse while idle is ignored
    ram_ack = 1'b1;
    step(); chk("stray_ack_idle", O_IDLE);
    ram_ack = 1'b0;
    step(); chk("stray_ack_idle2", O_IDLE);

    // Read miss, victim way 1
    sys_rd = 1'b1; hit = 1'b0; fifo = 1'b1;
    step(); chk("rdmiss_lookup", O_IDLE);
    step(); chk("rdmiss_wait1", O_RAMR);
    step(); chk("rdmiss_wait2", O_RAMR);
    step(); chk("rdmiss_wait3", O_RAMR);
    ram_ack = 1'b1;
    step(); chk("rdmiss_fill", O_FIL1);
    ram_ack = 1'b0; sys_rd = 1'b0; fifo = 1'b0;
    step(); chk("rdmiss_idle", O_IDLE);

    // Write miss (no allocate)
    sys_wr = 1'b1; hit = 1'b0;
    step(); chk("wrmiss_lookup", O_IDLE);
    step(); chk("wrmiss_wait1", O_RAMW);
    step(); chk("wrmiss_wait2", O_RAMW);
    ram_ack = 1'b1;
    step(); chk("wrmiss_ack", O_ACK);
    ram_ack = 1'b0; sys_wr = 1'b0;
    step(); chk("wrmiss_idle", O_IDLE);

    // Read and write together: the read takes priority
    sys_rd = 1'b1; sys_wr = 1'b1; hit = 1'b1;
    step(); chk("rdwr_lookup", O_IDLE);
    step(); chk("rdwr_read_ack", O_ACK);
    sys_rd = 1'b0; sys_wr = 1'b0;
    step(); chk("rdwr_idle", O_IDLE);

    // Reset asserted in the middle of a RAM read
    sys_rd = 1'b1; hit = 1'b0;
    step(); chk("rst_lookup", O_IDLE);
    step(); chk("rst_rdmem", O_RAMR);
    #2;
    not_reset = 1'b0;
    #1;
    chk("rst_async_clear", O_IDLE);
    sys_rd = 1'b0;
    @(negedge clk);
    not_reset = 1'b1;
    step(); chk("rst_release_idle1", O_IDLE);
    step(); chk("rst_release_idle2", O_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
